// File: rtl/rr_dec_arbiter4_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter with an
// active-low decoded grant bus.
package rr_dec_arbiter4_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First asserted request at or after ptr, searching circularly.
    function automatic pick_t rr_pick(input logic [0:N_REQ-1] req, input logic [1:0] ptr);
        pick_t      res;
        logic [1:0] idx;
        res = '{found: 1'b0, idx: 2'd0};
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + 2'(k);
            if ((res.found == 1'b0) && (req[idx] == 1'b1)) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_dec_arbiter4_dec2to4_n.sv
// 2-to-4 decoder with active-low enable and active-low outputs, built from
// inverters and 3-input NANDs. Select is {x, y}; w[0] corresponds to select 0.
module dec2to4_n (
    input  logic       x,
    input  logic       y,
    input  logic       z_n,
    output logic [0:3] w
);

    logic x_b_s;
    logic y_b_s;
    logic en_s;

    assign x_b_s = ~x;
    assign y_b_s = ~y;
    assign en_s  = ~z_n;

    assign w[0] = ~(x_b_s & y_b_s & en_s);
    assign w[1] = ~(x_b_s & y     & en_s);
    assign w[2] = ~(x     & y_b_s & en_s);
    assign w[3] = ~(x     & y     & en_s);

endmodule

// File: rtl/rr_dec_arbiter4.sv
// Round-robin arbiter for four requesters with hold-timeout watchdog and a
// single dead cycle between grants. All outputs come from registers.
module rr_dec_arbiter4
    import rr_dec_arbiter4_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:N_REQ-1] req,
    input  logic             done,
    output logic [0:N_REQ-1] gnt_n,
    output logic [1:0]       gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam int              HC_W      = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);
    localparam logic [HC_W-1:0] HOLD_SAT  = {HC_W{1'b1}};
    localparam logic [HC_W-1:0] HOLD_ONE  = HC_W'(1);
    localparam logic            TMO_EN    = (HOLD_MAX != 0) ? 1'b1 : 1'b0;

    arb_state_e      state_r;
    logic [1:0]      ptr_r;
    logic [1:0]      gnt_id_r;
    logic [HC_W-1:0] hold_cnt_r;
    logic            busy_r;
    logic            timeout_r;

    pick_t           pick_s;
    logic            cur_req_s;
    logic            tmo_hit_s;
    logic            release_s;
    logic            dec_en_n_s;

    // Winner selection and release conditions for the current grantee.
    always_comb begin
        pick_s    = rr_pick(req, ptr_r);
        cur_req_s = req[gnt_id_r];
        tmo_hit_s = TMO_EN & (hold_cnt_r == HOLD_LAST);
        release_s = done | ~cur_req_s | tmo_hit_s;
    end

    // Arbitration FSM; busy/timeout are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ptr_r      <= 2'd0;
            gnt_id_r   <= 2'd0;
            hold_cnt_r <= '0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_GAP: begin
                    timeout_r <= 1'b0;
                    if (pick_s.found) begin
                        state_r    <= S_GRANT;
                        gnt_id_r   <= pick_s.idx;
                        hold_cnt_r <= '0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (release_s) begin
                        state_r   <= S_GAP;
                        busy_r    <= 1'b0;
                        ptr_r     <= gnt_id_r + 2'd1;
                        // A voluntary release on the limit cycle is not a timeout.
                        timeout_r <= tmo_hit_s & ~done & cur_req_s;
                    end else begin
                        busy_r     <= 1'b1;
                        timeout_r  <= 1'b0;
                        hold_cnt_r <= (hold_cnt_r == HOLD_SAT) ? hold_cnt_r : hold_cnt_r + HOLD_ONE;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    busy_r    <= 1'b0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign dec_en_n_s = ~busy_r;
    assign gnt_id     = gnt_id_r;
    assign busy       = busy_r;
    assign timeout    = timeout_r;

    dec2to4_n u_gnt_dec (
        .x   (gnt_id_r[1]),
        .y   (gnt_id_r[0]),
        .z_n (dec_en_n_s),
        .w   (gnt_n)
    );

endmodule
